// File: rtl/axil_bram_slave.sv
// axil_bram_slave
// ---------------------------------------------------------------------------
// AXI4-Lite slave endpoint in front of a single-port, word-addressed on-chip
// memory with 32-bit words. One outstanding transaction per direction; the
// write and read channels run independent state machines that share the
// single memory port. On a same-cycle conflict the write wins and the read
// retries on the following cycle, so it returns the freshly written data.
//
// Out-of-range word indices (index >= DEPTH) answer SLVERR, never touch the
// memory and return zero read data. Memory contents are not reset.
//
// Optional build macro:
//   AXIL_BRAM_RD_PIPE_EN - adds an R_PIPE stage that registers the memory
//                          output before it is presented on RDATA (+1 cycle
//                          of read latency).
//
// Parameters:
//   ADDR_WIDTH - byte-address width of AWADDR/ARADDR
//   DEPTH      - number of 32-bit words, must be <= 2**(ADDR_WIDTH-2)
//
// Ports:
//   ACLK, ARESETN           - clock (rising edge), asynchronous active-low reset
//   S_AXI_AW*               - write address channel (AWPROT ignored)
//   S_AXI_W*                - write data channel, WSTRB = byte enables
//   S_AXI_B*                - write response channel
//   S_AXI_AR*               - read address channel (ARPROT ignored)
//   S_AXI_R*                - read data channel
// ---------------------------------------------------------------------------
module axil_bram_slave #(
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]            S_AXI_AWPROT,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [31:0]           S_AXI_WDATA,
   input  logic [3:0]            S_AXI_WSTRB,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]            S_AXI_ARPROT,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   output logic [31:0]           S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY
);

   localparam int IW = ADDR_WIDTH - 2;                      // word-index width
   localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;     // memory address width
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
   // R_PIPE is only reachable when the read pipeline stage is built in.
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_PIPE, R_RESP} r_state_t;

   // ---------------- write channel state ----------------
   w_state_t        w_state_reg, w_state_next;
   logic            aw_held_reg, aw_held_next;
   logic            w_held_reg, w_held_next;
   logic [IW-1:0]   aw_idx_reg, aw_idx_next;
   logic [31:0]     w_data_reg, w_data_next;
   logic [3:0]      w_strb_reg, w_strb_next;
   logic            awready_reg, awready_next;
   logic            wready_reg, wready_next;
   logic [1:0]      bresp_reg, bresp_next;

   // ---------------- read channel state ----------------
   r_state_t        r_state_reg, r_state_next;
   logic [IW-1:0]   ar_idx_reg, ar_idx_next;
   logic            arready_reg, arready_next;
   logic [1:0]      rresp_reg, rresp_next;

   logic            w_err, r_err, w_commit, mem_we, mem_re;
   logic [MW-1:0]   mem_addr;
   logic [31:0]     mem_q, rd_word;

   assign w_err    = 32'(aw_idx_reg) >= 32'(DEPTH);
   assign r_err    = 32'(ar_idx_reg) >= 32'(DEPTH);
   assign w_commit = (w_state_reg == W_COMMIT);

   // ---------------- write FSM ----------------
   always_comb begin
      w_state_next = w_state_reg;
      aw_held_next = aw_held_reg;
      w_held_next  = w_held_reg;
      aw_idx_next  = aw_idx_reg;
      w_data_next  = w_data_reg;
      w_strb_next  = w_strb_reg;
      bresp_next   = bresp_reg;
      case (w_state_reg)
         W_IDLE: begin
            // AW and W are captured independently, in either order.
            if (S_AXI_AWVALID && awready_reg) begin
               aw_held_next = 1'b1;
               aw_idx_next  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (S_AXI_WVALID && wready_reg) begin
               w_held_next = 1'b1;
               w_data_next = S_AXI_WDATA;
               w_strb_next = S_AXI_WSTRB;
            end
            if (aw_held_next && w_held_next)
               w_state_next = W_COMMIT;
         end
         W_COMMIT: begin
            aw_held_next = 1'b0;
            w_held_next  = 1'b0;
            bresp_next   = w_err ? RESP_SLVERR : RESP_OKAY;
            w_state_next = W_RESP;
         end
         W_RESP: begin
            if (S_AXI_BREADY)
               w_state_next = W_IDLE;
         end
         default: w_state_next = W_IDLE;
      endcase
      // Readys are registered: they reflect the state being entered.
      awready_next = (w_state_next == W_IDLE) && !aw_held_next;
      wready_next  = (w_state_next == W_IDLE) && !w_held_next;
   end

   // ---------------- read FSM ----------------
   always_comb begin
      r_state_next = r_state_reg;
      ar_idx_next  = ar_idx_reg;
      rresp_next   = rresp_reg;
      case (r_state_reg)
         R_IDLE: begin
            if (S_AXI_ARVALID && arready_reg) begin
               ar_idx_next  = S_AXI_ARADDR[ADDR_WIDTH-1:2];
               r_state_next = R_ISSUE;
            end
         end
         R_ISSUE: begin
            // The memory port is taken by a write commit: retry next cycle.
            if (!w_commit) begin
               rresp_next = r_err ? RESP_SLVERR : RESP_OKAY;
`ifdef AXIL_BRAM_RD_PIPE_EN
               r_state_next = R_PIPE;
`else
               r_state_next = R_RESP;
`endif
            end
         end
`ifdef AXIL_BRAM_RD_PIPE_EN
         R_PIPE: r_state_next = R_RESP;
`endif
         R_RESP: begin
            if (S_AXI_RREADY)
               r_state_next = R_IDLE;
         end
         default: r_state_next = R_IDLE;
      endcase
      arready_next = (r_state_next == R_IDLE);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state_reg <= W_IDLE;
         aw_held_reg <= 1'b0;
         w_held_reg  <= 1'b0;
         aw_idx_reg  <= '0;
         w_data_reg  <= '0;
         w_strb_reg  <= '0;
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
         r_state_reg <= R_IDLE;
         ar_idx_reg  <= '0;
         arready_reg <= 1'b0;
         rresp_reg   <= RESP_OKAY;
      end else begin
         w_state_reg <= w_state_next;
         aw_held_reg <= aw_held_next;
         w_held_reg  <= w_held_next;
         aw_idx_reg  <= aw_idx_next;
         w_data_reg  <= w_data_next;
         w_strb_reg  <= w_strb_next;
         awready_reg <= awready_next;
         wready_reg  <= wready_next;
         bresp_reg   <= bresp_next;
         r_state_reg <= r_state_next;
         ar_idx_reg  <= ar_idx_next;
         arready_reg <= arready_next;
         rresp_reg   <= rresp_next;
      end
   end

   // ---------------- memory: one byte-wide array per lane, single port ----------------
   assign mem_we   = w_commit && !w_err;
   assign mem_re   = (r_state_reg == R_ISSUE) && !w_commit && !r_err;
   assign mem_addr = w_commit ? aw_idx_reg[MW-1:0] : ar_idx_reg[MW-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
         logic [7:0] mem_b [DEPTH];
         logic [7:0] q_reg;
         always_ff @(posedge ACLK) begin
            if (mem_we && w_strb_reg[gi])
               mem_b[mem_addr] <= w_data_reg[gi*8 +: 8];
            if (mem_re)
               q_reg <= mem_b[mem_addr];
         end
         assign mem_q[gi*8 +: 8] = q_reg;
      end
   endgenerate

`ifdef AXIL_BRAM_RD_PIPE_EN
   logic [31:0] rd_pipe_reg;
   always_ff @(posedge ACLK) begin
      if (r_state_reg == R_PIPE)
         rd_pipe_reg <= mem_q;
   end
   assign rd_word = rd_pipe_reg;
`else
   assign rd_word = mem_q;
`endif

   // ---------------- outputs ----------------
   assign S_AXI_AWREADY = awready_reg;
   assign S_AXI_WREADY  = wready_reg;
   assign S_AXI_BVALID  = (w_state_reg == W_RESP);
   assign S_AXI_BRESP   = bresp_reg;
   assign S_AXI_ARREADY = arready_reg;
   assign S_AXI_RVALID  = (r_state_reg == R_RESP);
   assign S_AXI_RRESP   = rresp_reg;
   // The memory output register is not reset, so data is gated to zero
   // outside a valid OKAY response (covers reset and SLVERR).
   assign S_AXI_RDATA   = (S_AXI_RVALID && rresp_reg == RESP_OKAY) ? rd_word : 32'h0;

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
